debounce_edge_detect: RTL and testbench
=======================================

// Module: debounce_edge_detect
// PURPOSE
//   Conditions a raw asynchronous input (button, external strobe) into clean
//   single-cycle event pulses. It has three stages:
//   - SYNC_STAGES-deep synchronizer.
//   - Stability-qualified debounce FSM.
//   - Rise/fall pulse generator.
//   rise_pulse drives the pulse stretcher's in_pulse directly.
//   glitch_count gives visibility of rejected bounces.
// PARAMETERS
//   SYNC_STAGES     2   flops in synchronizer chain; legal 2..4
//   DEBOUNCE_CYCLES 8   consecutive equal samples needed to accept a new level; legal 2..2^CNT_W-1
//   CNT_W           4   debounce counter width
//   GLITCH_W        8   glitch counter width
// PORTS
//   clk           in   1         single clock; all flops rising-edge
//   rst           in   1         synchronous, active-high reset
//   async_in      in   1         raw, unsynchronized input
//   clear_glitch  in   1         synchronous clear of glitch_count
//   level_out     out  1         debounced level (registered)
//   rise_pulse    out  1         1-cycle pulse on accepted 0->1 (registered)
//   fall_pulse    out  1         1-cycle pulse on accepted 1->0 (registered)
//   glitch_count  out  GLITCH_W  saturating count of rejected level changes
// BEHAVIOUR
//   Reset (rst=1 at an edge):
//   - Sync chain, cnt, level_out, rise_pulse, fall_pulse and glitch_count all go to 0.
//   - State goes to LOW.
//   - rst dominates every other input.
//   Synchronizer: s = last flop of the chain. The FSM acts only on s, never on async_in.
//   FSM states: LOW, LOW_CHK, HIGH, HIGH_CHK.
//   - LOW:      s=1 -> LOW_CHK, cnt<=1; else stay.
//   - LOW_CHK:  s=0 -> LOW, glitch event.
//               s=1 && cnt==DEBOUNCE_CYCLES-1 -> HIGH, level_out<=1, rise_pulse<=1.
//               else cnt<=cnt+1.
//   - HIGH:     s=0 -> HIGH_CHK, cnt<=1; else stay.
//   - HIGH_CHK: s=1 -> HIGH, glitch event.
//               s=0 && cnt==DEBOUNCE_CYCLES-1 -> LOW, level_out<=0, fall_pulse<=1.
//               else cnt<=cnt+1.
//   Pulses:
//   - rise_pulse/fall_pulse are high for exactly one cycle: the first cycle of the new level_out value.
//   - Otherwise they are 0. The two are never high together.
//   Latency:
//   - Take edge 0 as the first edge that samples the new async_in value, held stable.
//   - level_out and the pulse update after edge SYNC_STAGES-1+DEBOUNCE_CYCLES (edge 9 at defaults).
//   - Metastability may add one cycle; the bench uses clean setup and expects exact values.
//   Pulse spacing: consecutive rise_pulses are at least 2*DEBOUNCE_CYCLES cycles apart.
//   glitch_count:
//   - Increments by 1 on each glitch event.
//   - Saturates at all-ones and does not wrap.
//   - clear_glitch=1 loads 0 and wins over a simultaneous glitch event (result 0).
//   Reset mid-operation:
//   - Any in-progress check is abandoned.
//   - No rise/fall pulse and no glitch increment are produced.
//   - If async_in is high when rst releases, the full latency applies before rise_pulse.
//   Counter: cnt never exceeds DEBOUNCE_CYCLES-1. cnt holds its value in LOW/HIGH; its value there is don't-care.
// TESTING
//   1. rst=1 for 3 cycles, async_in=1 -> all outputs 0 throughout.
//      After release: rise_pulse exactly 9 cycles after the first sample.
//   2. async_in 0->1, held 20 cycles (defaults) -> level_out=1 from edge 9.
//      rise_pulse=1 at edge 9 only; glitch_count=0.
//   3. async_in high for 5 cycles, then low -> level_out stays 0, no pulses, glitch_count=1.
//   4. From HIGH, async_in 1->0, held -> fall_pulse=1 for one cycle at edge 9, level_out=0.
//      Bounce 1-0-1 within 3 cycles from HIGH -> level_out stays 1, glitch_count increments.
//   5. GLITCH_W=2, 5 glitches -> glitch_count=3 (saturated).
//      clear_glitch on the same cycle as a 6th glitch -> glitch_count=0.
//   6. rst pulsed while in LOW_CHK with cnt=5 -> state LOW.
//      No rise_pulse on or after that edge; glitch_count unchanged (0 after reset).

Source files
------------

// File: rtl/debounce_edge_detect.sv
// Raw async input -> synchronizer -> stability-qualified debounce FSM -> registered
// level plus single-cycle rise/fall pulses, with a saturating count of rejected bounces.
module debounce_edge_detect #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 8,
  parameter int CNT_W           = 4,
  parameter int GLITCH_W        = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                async_in,
  input  logic                clear_glitch,
  output logic                level_out,
  output logic                rise_pulse,
  output logic                fall_pulse,
  output logic [GLITCH_W-1:0] glitch_count
);

  typedef enum logic [1:0] {LOW, LOW_CHK, HIGH, HIGH_CHK} state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;
  state_t                 state, state_nxt;
  logic [CNT_W-1:0]       cnt, cnt_nxt;
  logic                   level_nxt, rise_nxt, fall_nxt, glitch_ev;

  always_ff @(posedge clk) begin
    if (rst) sync_q <= '0;
    else     sync_q <= {sync_q[SYNC_STAGES-2:0], async_in};
  end

  assign s = sync_q[SYNC_STAGES-1];

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    level_nxt = level_out;
    rise_nxt  = 1'b0;
    fall_nxt  = 1'b0;
    glitch_ev = 1'b0;
    case (state)
      LOW: if (s) begin
        state_nxt = LOW_CHK;
        cnt_nxt   = CNT_W'(1);
      end
      LOW_CHK: begin
        if (!s) begin
          state_nxt = LOW;
          glitch_ev = 1'b1;
        end else if (cnt == CNT_LAST) begin
          state_nxt = HIGH;
          level_nxt = 1'b1;
          rise_nxt  = 1'b1;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      HIGH: if (!s) begin
        state_nxt = HIGH_CHK;
        cnt_nxt   = CNT_W'(1);
      end
      HIGH_CHK: begin
        if (s) begin
          state_nxt = HIGH;
          glitch_ev = 1'b1;
        end else if (cnt == CNT_LAST) begin
          state_nxt = LOW;
          level_nxt = 1'b0;
          fall_nxt  = 1'b1;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      default: state_nxt = LOW;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= LOW;
      cnt        <= '0;
      level_out  <= 1'b0;
      rise_pulse <= 1'b0;
      fall_pulse <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      level_out  <= level_nxt;
      rise_pulse <= rise_nxt;
      fall_pulse <= fall_nxt;
    end
  end

  // clear wins over a same-cycle glitch; the count sticks at all-ones
  always_ff @(posedge clk) begin
    if (rst || clear_glitch)             glitch_count <= '0;
    else if (glitch_ev && !(&glitch_count)) glitch_count <= glitch_count + GLITCH_W'(1);
  end

endmodule

// File: tb/tb_debounce_edge_detect.sv
// Bench for debounce_edge_detect: run-length reference model feeding a scoreboard,
// plus directed edge-timing checks; a second instance with GLITCH_W=2 covers saturation.
module tb_debounce_edge_detect;

  localparam int DEB = 8;

  logic       clk = 1'b0;
  logic       rst, async_in, clear_glitch;
  logic       level_out, rise_pulse, fall_pulse;
  logic [7:0] glitch_count;
  logic       s_level, s_rise, s_fall;
  logic [1:0] s_glitch;

  always #5 clk = ~clk;

  debounce_edge_detect u_dut (
    .clk(clk), .rst(rst), .async_in(async_in), .clear_glitch(clear_glitch),
    .level_out(level_out), .rise_pulse(rise_pulse), .fall_pulse(fall_pulse),
    .glitch_count(glitch_count)
  );

  debounce_edge_detect #(.GLITCH_W(2)) u_sat (
    .clk(clk), .rst(rst), .async_in(async_in), .clear_glitch(clear_glitch),
    .level_out(s_level), .rise_pulse(s_rise), .fall_pulse(s_fall),
    .glitch_count(s_glitch)
  );

  typedef struct {
    logic lvl;
    logic rise;
    logic fall;
    int   gc;
    int   gc2;
  } exp_t;

  exp_t sbq[$];
  int   n_chk = 0, n_pass = 0;

  // reference model state: 2-flop sync history and run length of opposing samples
  logic m_s1 = 0, m_s2 = 0, m_lvl = 0, m_rise = 0, m_fall = 0;
  int   m_run = 0, m_gc = 0, m_gc2 = 0;

  int edge_n, rise_at, fall_at, nrise, nfall;

  task automatic chk(input string tag, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
  endtask

  task automatic model(input logic a, input logic r, input logic c);
    logic s_m, ev;
    if (r) begin
      m_s1 = 0; m_s2 = 0; m_lvl = 0; m_run = 0;
      m_rise = 0; m_fall = 0; m_gc = 0; m_gc2 = 0;
    end else begin
      s_m = m_s2; m_s2 = m_s1; m_s1 = a;
      m_rise = 0; m_fall = 0; ev = 0;
      if (s_m != m_lvl) begin
        m_run++;
        if (m_run == DEB) begin
          m_lvl = s_m; m_rise = s_m; m_fall = !s_m; m_run = 0;
        end
      end else begin
        ev = (m_run > 0);
        m_run = 0;
      end
      if (c) begin
        m_gc = 0; m_gc2 = 0;
      end else if (ev) begin
        if (m_gc < 255) m_gc++;
        if (m_gc2 < 3)  m_gc2++;
      end
    end
  endtask

  task automatic step(input logic a, input logic r, input logic c);
    exp_t e;
    async_in = a; rst = r; clear_glitch = c;
    @(posedge clk);
    model(a, r, c);
    sbq.push_back('{m_lvl, m_rise, m_fall, m_gc, m_gc2});
    #1;
    e = sbq.pop_front();
    chk("level",  int'(level_out),    int'(e.lvl));
    chk("rise",   int'(rise_pulse),   int'(e.rise));
    chk("fall",   int'(fall_pulse),   int'(e.fall));
    chk("glitch", int'(glitch_count), e.gc);
    chk("sat_glitch", int'(s_glitch), e.gc2);
    chk("sat_level",  int'(s_level),  int'(e.lvl));
    chk("sat_pulses", int'({s_rise, s_fall}), int'({e.rise, e.fall}));
    if (rise_pulse) begin nrise++; rise_at = edge_n; end
    if (fall_pulse) begin nfall++; fall_at = edge_n; end
    edge_n++;
  endtask

  // hold async_in for n edges; edge 0 is the first edge that samples the value
  task automatic hold(input logic a, input int n);
    edge_n = 0; rise_at = -1; fall_at = -1; nrise = 0; nfall = 0;
    for (int i = 0; i < n; i++) step(a, 1'b0, 1'b0);
  endtask

  initial begin
    rst = 1'b1; async_in = 1'b0; clear_glitch = 1'b0;
    #2;
    step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    chk("reset_level", int'(level_out), 0);
    chk("reset_glitch", int'(glitch_count), 0);

    // reset held with input high, then full latency after release
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0);
    chk("rst_hi_outs", int'({level_out, rise_pulse, fall_pulse}), 0);
    hold(1'b1, 20);
    chk("t1_rise_edge", rise_at, 9);
    chk("t1_rise_cnt", nrise, 1);

    // clean fall from HIGH
    hold(1'b0, 20);
    chk("t4_fall_edge", fall_at, 9);
    chk("t4_fall_cnt", nfall, 1);
    chk("t4_level", int'(level_out), 0);

    // clean rise
    hold(1'b1, 20);
    chk("t2_rise_edge", rise_at, 9);
    chk("t2_rise_cnt", nrise, 1);
    chk("t2_level", int'(level_out), 1);
    chk("t2_glitch", int'(glitch_count), 0);

    // 1-0-1 bounce while HIGH
    hold(1'b0, 1);
    hold(1'b1, 10);
    chk("t4b_level", int'(level_out), 1);
    chk("t4b_nofall", nfall, 0);
    chk("t4b_glitch", int'(glitch_count), 1);
    hold(1'b0, 20);
    chk("t4b_fall_edge", fall_at, 9);

    // high for 5 cycles then low: rejected
    hold(1'b1, 5);
    hold(1'b0, 10);
    chk("t3_level", int'(level_out), 0);
    chk("t3_norise", nrise, 0);
    chk("t3_glitch", int'(glitch_count), 2);

    // saturation on the 2-bit instance
    step(1'b0, 1'b0, 1'b1);
    chk("clr_glitch", int'(glitch_count), 0);
    for (int g = 0; g < 5; g++) begin
      hold(1'b1, 2);
      hold(1'b0, 4);
    end
    chk("t5_sat", int'(s_glitch), 3);
    chk("t5_wide", int'(glitch_count), 5);
    // sixth glitch lands on the 5th edge of the pattern; clear on that edge
    hold(1'b1, 2);
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0);
    chk("t5_clr_sat", int'(s_glitch), 0);
    chk("t5_clr_wide", int'(glitch_count), 0);
    hold(1'b0, 4);

    // build up a glitch count, then reset mid-check (cnt=5 after edge 6)
    hold(1'b1, 3);
    hold(1'b0, 6);
    chk("t6_pre_glitch", int'(glitch_count), 1);
    hold(1'b1, 7);
    step(1'b0, 1'b1, 1'b0);
    chk("t6_rst_glitch", int'(glitch_count), 0);
    hold(1'b0, 15);
    chk("t6_norise", nrise, 0);
    chk("t6_level", int'(level_out), 0);
    chk("t6_glitch", int'(glitch_count), 0);

    // reset mid-check with input staying high: full latency from release
    hold(1'b1, 5);
    step(1'b1, 1'b1, 1'b0);
    hold(1'b1, 15);
    chk("t6b_rise_edge", rise_at, 9);
    chk("t6b_rise_cnt", nrise, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
